// File: rtl/traffic_phase_sequencer.sv
// Timed Moore controller for per-lane green/yellow lamps with day phases, night flash,
// latched pedestrian walk and emergency preemption; lamps not lit green or yellow are red.
module traffic_phase_sequencer #(
  parameter int LANES         = 8,
  parameter int PHASES        = 4,
  parameter int GREEN_CYCLES  = 20,
  parameter int YELLOW_CYCLES = 4,
  parameter int CLEAR_CYCLES  = 2,
  parameter int PED_CYCLES    = 10,
  parameter int CNT_W         = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     timeSignal,
  input  logic                     pedSignal,
  input  logic                     emgSignal,
  input  logic [LANES-1:0]         emgLane,
  input  logic [PHASES*LANES-1:0]  phaseMask,
  output logic [LANES-1:0]         greenOut,
  output logic [LANES-1:0]         yellowOut,
  output logic                     walkOut,
  output logic [1:0]               trafficMode
);

  localparam int PH_W = (PHASES > 1) ? $clog2(PHASES) : 1;

  localparam logic [CNT_W-1:0] GRN_LD = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YEL_LD = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLR_LD = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] PED_LD = CNT_W'(PED_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(PHASES - 1);

  typedef enum logic [2:0] {
    ST_GREEN       = 3'd0,
    ST_YELLOW      = 3'd1,
    ST_CLEAR       = 3'd2,
    ST_PED_WALK    = 3'd3,
    ST_EMG_HOLD    = 3'd4,
    ST_NIGHT_FLASH = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic              ped_pending_q, ped_pending_d;
  logic              blink_q, blink_d;
  logic [LANES-1:0]  green_q, green_d;
  logic [LANES-1:0]  yellow_q, yellow_d;
  logic              walk_q, walk_d;
  logic [1:0]        mode_q, mode_d;
  logic              timer_done_s;
  logic [LANES-1:0]  mask_s [PHASES];

  for (genvar gp = 0; gp < PHASES; gp++) begin : g_mask
    assign mask_s[gp] = phaseMask[gp*LANES +: LANES];
  end

  assign timer_done_s = (timer_q == {CNT_W{1'b0}});

  // Next-state, timer, phase, pedestrian latch and blink logic
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    timer_d       = timer_q - CNT_W'(1);
    blink_d       = blink_q;
    ped_pending_d = ped_pending_q | (pedSignal & (state_q != ST_PED_WALK));
    case (state_q)
      ST_GREEN: begin
        if (emgSignal || timer_done_s) begin
          state_d = ST_YELLOW;
          timer_d = YEL_LD;
        end else begin
          state_d = ST_GREEN;
        end
      end
      ST_YELLOW: begin
        if (timer_done_s) begin
          state_d = ST_CLEAR;
          timer_d = CLR_LD;
          phase_d = (phase_q == PH_LAST) ? {PH_W{1'b0}} : phase_q + PH_W'(1);
        end else begin
          state_d = ST_YELLOW;
        end
      end
      ST_CLEAR: begin
        // Exit priority: emergency, then pedestrian, then night, then day green
        if (!timer_done_s) begin
          state_d = ST_CLEAR;
        end else if (emgSignal) begin
          state_d = ST_EMG_HOLD;
          timer_d = {CNT_W{1'b0}};
        end else if (ped_pending_q) begin
          state_d       = ST_PED_WALK;
          timer_d       = PED_LD;
          ped_pending_d = 1'b0;
        end else if (timeSignal) begin
          state_d = ST_NIGHT_FLASH;
          timer_d = YEL_LD;
          blink_d = 1'b1;
        end else begin
          state_d = ST_GREEN;
          timer_d = GRN_LD;
        end
      end
      ST_PED_WALK: begin
        if (emgSignal) begin
          state_d       = ST_CLEAR;
          timer_d       = CLR_LD;
          ped_pending_d = 1'b1;
        end else if (timer_done_s) begin
          state_d = ST_CLEAR;
          timer_d = CLR_LD;
        end else begin
          state_d = ST_PED_WALK;
        end
      end
      ST_EMG_HOLD: begin
        if (emgSignal) begin
          state_d = ST_EMG_HOLD;
          timer_d = timer_q;
        end else begin
          state_d = ST_CLEAR;
          timer_d = CLR_LD;
        end
      end
      ST_NIGHT_FLASH: begin
        if (emgSignal) begin
          state_d = ST_CLEAR;
          timer_d = CLR_LD;
          blink_d = 1'b0;
        end else if (!timeSignal) begin
          state_d = ST_CLEAR;
          timer_d = CLR_LD;
          phase_d = {PH_W{1'b0}};
          blink_d = 1'b0;
        end else if (timer_done_s) begin
          timer_d = YEL_LD;
          blink_d = ~blink_q;
        end else begin
          state_d = ST_NIGHT_FLASH;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        timer_d = CLR_LD;
      end
    endcase
  end

  // Lamp decode of the upcoming state, registered so lamps follow the state register
  always_comb begin
    green_d  = {LANES{1'b0}};
    yellow_d = {LANES{1'b0}};
    walk_d   = 1'b0;
    mode_d   = 2'b00;
    case (state_d)
      ST_GREEN:       green_d  = mask_s[phase_d];
      ST_YELLOW:      yellow_d = mask_s[phase_d];
      ST_CLEAR:       mode_d   = 2'b00;
      ST_PED_WALK: begin
        walk_d = 1'b1;
        mode_d = 2'b10;
      end
      ST_EMG_HOLD: begin
        green_d = emgLane;
        mode_d  = 2'b11;
      end
      ST_NIGHT_FLASH: begin
        yellow_d = {LANES{blink_d}};
        mode_d   = 2'b01;
      end
      default:        mode_d   = 2'b00;
    endcase
  end

  // State, timer and lamp registers with synchronous reset into all-red clearance
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_CLEAR;
      phase_q       <= {PH_W{1'b0}};
      timer_q       <= CLR_LD;
      ped_pending_q <= 1'b0;
      blink_q       <= 1'b0;
      green_q       <= {LANES{1'b0}};
      yellow_q      <= {LANES{1'b0}};
      walk_q        <= 1'b0;
      mode_q        <= 2'b00;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      timer_q       <= timer_d;
      ped_pending_q <= ped_pending_d;
      blink_q       <= blink_d;
      green_q       <= green_d;
      yellow_q      <= yellow_d;
      walk_q        <= walk_d;
      mode_q        <= mode_d;
    end
  end

  assign greenOut    = green_q;
  assign yellowOut   = yellow_q;
  assign walkOut     = walk_q;
  assign trafficMode = mode_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed table-driven bench for traffic_phase_sequencer with default parameters
// and phase masks 03/0C/30/C0; cycle 0 is the first cycle after reset.
module tb_traffic_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        timeSignal = 1'b0;
  logic        pedSignal = 1'b0;
  logic        emgSignal = 1'b0;
  logic [7:0]  emgLane = 8'h00;
  logic [31:0] phaseMask = {8'hC0, 8'h30, 8'h0C, 8'h03};
  logic [7:0]  greenOut;
  logic [7:0]  yellowOut;
  logic        walkOut;
  logic [1:0]  trafficMode;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  traffic_phase_sequencer dut (
    .clk(clk), .rst(rst), .timeSignal(timeSignal), .pedSignal(pedSignal),
    .emgSignal(emgSignal), .emgLane(emgLane), .phaseMask(phaseMask),
    .greenOut(greenOut), .yellowOut(yellowOut), .walkOut(walkOut),
    .trafficMode(trafficMode)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         new_sc;
    int         c;
    bit         r, p, e, t;
    logic [7:0] lane, g, y;
    bit         w;
    logic [1:0] m;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit ns, input int c, input bit r, input bit p, input bit e,
                     input bit t, input logic [7:0] ln, input logic [7:0] g,
                     input logic [7:0] y, input bit w, input logic [1:0] m);
    vec_t v;
    v.new_sc = ns; v.c = c; v.r = r; v.p = p; v.e = e; v.t = t;
    v.lane = ln; v.g = g; v.y = y; v.w = w; v.m = m;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] eg, input logic [7:0] ey,
                     input logic ew, input logic [1:0] em);
    checks++;
    if ({greenOut, yellowOut, walkOut, trafficMode} !== {eg, ey, ew, em}) begin
      errors++;
      $display("FAIL %s cyc=%0d got g=%h y=%h w=%b m=%b want g=%h y=%h w=%b m=%b",
               name, cyc, greenOut, yellowOut, walkOut, trafficMode, eg, ey, ew, em);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    checks++;
    if ((greenOut & yellowOut) !== 8'h00) begin
      errors++;
      $display("FAIL excl cyc=%0d got g=%h y=%h want no overlap", cyc, greenOut, yellowOut);
    end
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    pedSignal = 1'b0; emgSignal = 1'b0; timeSignal = 1'b0; emgLane = 8'h00;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    // free run: 2 clear, 20 green, 4 yellow, 2 clear per phase
    add(1, 0,0,0,0,0,8'h00, 8'h00,8'h00,0,2'b00);
    add(0, 1,0,0,0,0,8'h00, 8'h00,8'h00,0,2'b00);
    add(0, 2,0,0,0,0,8'h00, 8'h03,8'h00,0,2'b00);
    add(0,21,0,0,0,0,8'h00, 8'h03,8'h00,0,2'b00);
    add(0,22,0,0,0,0,8'h00, 8'h00,8'h03,0,2'b00);
    add(0,25,0,0,0,0,8'h00, 8'h00,8'h03,0,2'b00);
    add(0,26,0,0,0,0,8'h00, 8'h00,8'h00,0,2'b00);
    add(0,27,0,0,0,0,8'h00, 8'h00,8'h00,0,2'b00);
    add(0,28,0,0,0,0,8'h00, 8'h0C,8'h00,0,2'b00);
    add(0,47,0,0,0,0,8'h00, 8'h0C,8'h00,0,2'b00);
    add(0,48,0,0,0,0,8'h00, 8'h00,8'h0C,0,2'b00);
    add(0,54,0,0,0,0,8'h00, 8'h30,8'h00,0,2'b00);
    add(0,80,0,0,0,0,8'h00, 8'hC0,8'h00,0,2'b00);
    add(0,100,0,0,0,0,8'h00,8'h00,8'hC0,0,2'b00);
    add(0,104,0,0,0,0,8'h00,8'h00,8'h00,0,2'b00);
    add(0,106,0,0,0,0,8'h00,8'h03,8'h00,0,2'b00);
    // pedestrian pulse at cycle 5
    add(1, 0,0,0,0,0,8'h00, 8'h00,8'h00,0,2'b00);
    add(0, 5,0,1,0,0,8'h00, 8'h03,8'h00,0,2'b00);
    add(0, 6,0,0,0,0,8'h00, 8'h03,8'h00,0,2'b00);
    add(0,22,0,0,0,0,8'h00, 8'h00,8'h03,0,2'b00);
    add(0,26,0,0,0,0,8'h00, 8'h00,8'h00,0,2'b00);
    add(0,27,0,0,0,0,8'h00, 8'h00,8'h00,0,2'b00);
    add(0,28,0,0,0,0,8'h00, 8'h00,8'h00,1,2'b10);
    add(0,37,0,0,0,0,8'h00, 8'h00,8'h00,1,2'b10);
    add(0,38,0,0,0,0,8'h00, 8'h00,8'h00,0,2'b00);
    add(0,39,0,0,0,0,8'h00, 8'h00,8'h00,0,2'b00);
    add(0,40,0,0,0,0,8'h00, 8'h0C,8'h00,0,2'b00);
    // emergency during green, live emgLane change, release
    add(1, 0,0,0,0,0,8'h00, 8'h00,8'h00,0,2'b00);
    add(0, 5,0,0,1,0,8'h08, 8'h03,8'h00,0,2'b00);
    add(0, 6,0,0,1,0,8'h08, 8'h00,8'h03,0,2'b00);
    add(0, 9,0,0,1,0,8'h08, 8'h00,8'h03,0,2'b00);
    add(0,10,0,0,1,0,8'h08, 8'h00,8'h00,0,2'b00);
    add(0,11,0,0,1,0,8'h08, 8'h00,8'h00,0,2'b00);
    add(0,12,0,0,1,0,8'h08, 8'h08,8'h00,0,2'b11);
    add(0,15,0,0,1,0,8'h81, 8'h08,8'h00,0,2'b11);
    add(0,16,0,0,1,0,8'h81, 8'h81,8'h00,0,2'b11);
    add(0,20,0,0,0,0,8'h81, 8'h81,8'h00,0,2'b11);
    add(0,21,0,0,0,0,8'h81, 8'h00,8'h00,0,2'b00);
    add(0,22,0,0,0,0,8'h81, 8'h00,8'h00,0,2'b00);
    add(0,23,0,0,0,0,8'h81, 8'h0C,8'h00,0,2'b00);
    // night from cycle 0, blink every 4 cycles, then day
    add(1, 0,0,0,0,1,8'h00, 8'h00,8'h00,0,2'b00);
    add(0, 1,0,0,0,1,8'h00, 8'h00,8'h00,0,2'b00);
    add(0, 2,0,0,0,1,8'h00, 8'h00,8'hFF,0,2'b01);
    add(0, 5,0,0,0,1,8'h00, 8'h00,8'hFF,0,2'b01);
    add(0, 6,0,0,0,1,8'h00, 8'h00,8'h00,0,2'b01);
    add(0, 9,0,0,0,1,8'h00, 8'h00,8'h00,0,2'b01);
    add(0,10,0,0,0,1,8'h00, 8'h00,8'hFF,0,2'b01);
    add(0,11,0,0,0,0,8'h00, 8'h00,8'hFF,0,2'b01);
    add(0,12,0,0,0,0,8'h00, 8'h00,8'h00,0,2'b00);
    add(0,13,0,0,0,0,8'h00, 8'h00,8'h00,0,2'b00);
    add(0,14,0,0,0,0,8'h00, 8'h03,8'h00,0,2'b00);
    // night entered after phase 1; leaving night restarts at phase 0
    add(1, 0,0,0,0,0,8'h00, 8'h00,8'h00,0,2'b00);
    add(0,28,0,0,0,1,8'h00, 8'h0C,8'h00,0,2'b00);
    add(0,48,0,0,0,1,8'h00, 8'h00,8'h0C,0,2'b00);
    add(0,52,0,0,0,1,8'h00, 8'h00,8'h00,0,2'b00);
    add(0,54,0,0,0,1,8'h00, 8'h00,8'hFF,0,2'b01);
    add(0,56,0,0,0,0,8'h00, 8'h00,8'hFF,0,2'b01);
    add(0,57,0,0,0,0,8'h00, 8'h00,8'h00,0,2'b00);
    add(0,58,0,0,0,0,8'h00, 8'h00,8'h00,0,2'b00);
    add(0,59,0,0,0,0,8'h00, 8'h03,8'h00,0,2'b00);
    // emergency aborts walk; walk re-served after release
    add(1, 0,0,0,0,0,8'h00, 8'h00,8'h00,0,2'b00);
    add(0, 5,0,1,0,0,8'h00, 8'h03,8'h00,0,2'b00);
    add(0, 6,0,0,0,0,8'h00, 8'h03,8'h00,0,2'b00);
    add(0,28,0,0,0,0,8'h00, 8'h00,8'h00,1,2'b10);
    add(0,30,0,0,1,0,8'h10, 8'h00,8'h00,1,2'b10);
    add(0,31,0,0,1,0,8'h10, 8'h00,8'h00,0,2'b00);
    add(0,32,0,0,1,0,8'h10, 8'h00,8'h00,0,2'b00);
    add(0,33,0,0,1,0,8'h10, 8'h10,8'h00,0,2'b11);
    add(0,35,0,0,0,0,8'h10, 8'h10,8'h00,0,2'b11);
    add(0,36,0,0,0,0,8'h10, 8'h00,8'h00,0,2'b00);
    add(0,37,0,0,0,0,8'h10, 8'h00,8'h00,0,2'b00);
    add(0,38,0,0,0,0,8'h10, 8'h00,8'h00,1,2'b10);
    add(0,47,0,0,0,0,8'h10, 8'h00,8'h00,1,2'b10);
    add(0,48,0,0,0,0,8'h10, 8'h00,8'h00,0,2'b00);
    add(0,49,0,0,0,0,8'h10, 8'h00,8'h00,0,2'b00);
    add(0,50,0,0,0,0,8'h10, 8'h0C,8'h00,0,2'b00);
    // reset mid-walk discards the request and restarts at phase 0
    add(1, 0,0,0,0,0,8'h00, 8'h00,8'h00,0,2'b00);
    add(0, 5,0,1,0,0,8'h00, 8'h03,8'h00,0,2'b00);
    add(0, 6,0,0,0,0,8'h00, 8'h03,8'h00,0,2'b00);
    add(0,28,0,0,0,0,8'h00, 8'h00,8'h00,1,2'b10);
    add(0,30,1,0,0,0,8'h00, 8'h00,8'h00,1,2'b10);
    add(0,31,0,0,0,0,8'h00, 8'h00,8'h00,0,2'b00);
    add(0,32,0,0,0,0,8'h00, 8'h00,8'h00,0,2'b00);
    add(0,33,0,0,0,0,8'h00, 8'h03,8'h00,0,2'b00);
    add(0,52,0,0,0,0,8'h00, 8'h03,8'h00,0,2'b00);
    add(0,53,0,0,0,0,8'h00, 8'h00,8'h03,0,2'b00);
    add(0,57,0,0,0,0,8'h00, 8'h00,8'h00,0,2'b00);
    add(0,59,0,0,0,0,8'h00, 8'h0C,8'h00,0,2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].new_sc) do_reset();
      else goto_cyc(vecs[i].c);
      rst = vecs[i].r; pedSignal = vecs[i].p; emgSignal = vecs[i].e;
      timeSignal = vecs[i].t; emgLane = vecs[i].lane;
      chk($sformatf("vec%0d", i), vecs[i].g, vecs[i].y, vecs[i].w, vecs[i].m);
    end

    // simultaneous emergency and pedestrian: emergency first, walk afterwards
    do_reset();
    goto_cyc(5);
    pedSignal = 1'b1; emgSignal = 1'b1; emgLane = 8'h04;
    step();
    pedSignal = 1'b0;
    chk("sim_yel", 8'h00, 8'h03, 1'b0, 2'b00);
    goto_cyc(11); chk("sim_clr", 8'h00, 8'h00, 1'b0, 2'b00);
    goto_cyc(12); chk("sim_emg", 8'h04, 8'h00, 1'b0, 2'b11);
    goto_cyc(14); emgSignal = 1'b0;
    chk("sim_emg_end", 8'h04, 8'h00, 1'b0, 2'b11);
    goto_cyc(15); chk("sim_clr2", 8'h00, 8'h00, 1'b0, 2'b00);
    goto_cyc(17); chk("sim_walk", 8'h00, 8'h00, 1'b1, 2'b10);
    goto_cyc(26); chk("sim_walk_end", 8'h00, 8'h00, 1'b1, 2'b10);
    goto_cyc(27); chk("sim_clr3", 8'h00, 8'h00, 1'b0, 2'b00);
    goto_cyc(29); chk("sim_green", 8'h0C, 8'h00, 1'b0, 2'b00);

    // emergency raised mid-yellow: yellow completes, then clearance
    do_reset();
    goto_cyc(23);
    emgSignal = 1'b1; emgLane = 8'hF0;
    chk("yemg_23", 8'h00, 8'h03, 1'b0, 2'b00);
    goto_cyc(25); chk("yemg_25", 8'h00, 8'h03, 1'b0, 2'b00);
    goto_cyc(26); chk("yemg_clr", 8'h00, 8'h00, 1'b0, 2'b00);
    goto_cyc(28); chk("yemg_hold", 8'hF0, 8'h00, 1'b0, 2'b11);
    emgSignal = 1'b0;
    goto_cyc(29); chk("yemg_rel", 8'h00, 8'h00, 1'b0, 2'b00);
    goto_cyc(31); chk("yemg_green", 8'h0C, 8'h00, 1'b0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
